// File: rtl/qs_bank_sched_pkg.sv
// Shared types and sizing for the sort-bank scheduler.
package qs_bank_sched_pkg;

  localparam int unsigned BANKS_N = 4;
  localparam int unsigned N       = 8;
  localparam int unsigned BID_W   = $clog2(BANKS_N);
  localparam int unsigned LEN_W   = $clog2(N) + 1;

  typedef logic [BID_W-1:0] bank_id_t;
  typedef logic [LEN_W-1:0] len_t;

  // Bank lifecycle; each stage owns exactly one busy status.
  typedef enum logic [2:0] {
    BankIdle      = 3'd0,
    BankLoading   = 3'd1,
    BankReady     = 3'd2,
    BankSorting   = 3'd3,
    BankSorted    = 3'd4,
    BankUnloading = 3'd5
  } bank_status_t;

  // Status a bank moves to when the stage holding it in status s releases it.
  function automatic bank_status_t next_status(bank_status_t s);
    bank_status_t n;
    unique case (s)
      BankLoading:   n = BankReady;
      BankSorting:   n = BankSorted;
      BankUnloading: n = BankIdle;
      default:       n = s;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/qs_bank_sched_stage.sv
// One scheduling stage: round-robin pointer, ownership flag and grant register.
// Issues acquire/release strobes; the shared status array lives in the top.
module qs_bank_sched_stage
  import qs_bank_sched_pkg::*;
#(
  parameter int unsigned  BanksN    = 4,
  parameter int unsigned  BidW      = 2,
  parameter bank_status_t ReqState  = BankIdle,
  parameter bank_status_t BusyState = BankLoading
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req,
  input  logic            rel,
  input  logic            rel_veto,
  input  bank_status_t    ptr_state,
  output logic [BidW-1:0] ptr,
  output logic            acq,
  output bank_status_t    acq_state,
  output logic            rel_ok,
  output bank_status_t    rel_state,
  output logic            rel_err,
  output logic            gnt_r,
  output logic [BidW-1:0] idx_r
);

  logic [BidW-1:0] ptr_q;
  logic [BidW-1:0] idx_q;
  logic            own_q;
  logic            gnt_q;

  // Grant/release decode from registered state only; a release blocks a same-cycle grant.
  always_comb begin
    acq     = req & ~own_q & ~rel & (ptr_state == ReqState);
    rel_ok  = rel & own_q & ~rel_veto;
    rel_err = rel & ~own_q;
  end

  assign acq_state = BusyState;
  assign rel_state = next_status(BusyState);

  // Pointer, ownership and grant pulse; ptr wraps naturally since BanksN is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      idx_q <= '0;
      own_q <= 1'b0;
      gnt_q <= 1'b0;
    end else begin
      gnt_q <= acq;
      if (acq) begin
        idx_q <= ptr_q;
        ptr_q <= ptr_q + BidW'(1);
        own_q <= 1'b1;
      end else if (rel_ok) begin
        own_q <= 1'b0;
      end
    end
  end

  assign ptr   = ptr_q;
  assign gnt_r = gnt_q;
  assign idx_r = idx_q;

endmodule

// File: rtl/qs_bank_sched.sv
// Bank ownership scheduler for the enqueue, sort and dequeue controllers.
// Banks are acquired by each stage in strict round-robin order.
module qs_bank_sched
  import qs_bank_sched_pkg::*;
#(
  parameter int unsigned BANKS_N = qs_bank_sched_pkg::BANKS_N,
  parameter int unsigned N       = qs_bank_sched_pkg::N,
  localparam int unsigned BidW   = $clog2(BANKS_N),
  localparam int unsigned LenW   = $clog2(N) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enq_req,
  output logic            enq_gnt_r,
  output logic [BidW-1:0] enq_idx_r,
  input  logic            enq_rel,
  input  logic [LenW-1:0] enq_rel_len,
  input  logic            srt_req,
  output logic            srt_gnt_r,
  output logic [BidW-1:0] srt_idx_r,
  output logic [LenW-1:0] srt_len_r,
  input  logic            srt_rel,
  input  logic            deq_req,
  output logic            deq_gnt_r,
  output logic [BidW-1:0] deq_idx_r,
  output logic [LenW-1:0] deq_len_r,
  input  logic            deq_rel,
  output logic            idle_r,
  output logic            err_r
);

  localparam logic [LenW-1:0] LenMax = LenW'(N);

  bank_status_t    state_q [BANKS_N];
  bank_status_t    state_d [BANKS_N];
  logic [LenW-1:0] len_q   [BANKS_N];
  logic [LenW-1:0] len_d   [BANKS_N];
  logic [LenW-1:0] srt_len_q, deq_len_q;
  logic            err_q, err_d;
  logic            idle;
  logic            enq_len_bad;

  logic [BidW-1:0] enq_ptr, srt_ptr, deq_ptr;
  logic            enq_acq, srt_acq, deq_acq;
  logic            enq_rel_ok, srt_rel_ok, deq_rel_ok;
  logic            enq_rel_err, srt_rel_err, deq_rel_err;
  bank_status_t    enq_acq_st, srt_acq_st, deq_acq_st;
  bank_status_t    enq_rel_st, srt_rel_st, deq_rel_st;

  // An oversize length is an error and must leave the bank untouched.
  assign enq_len_bad = enq_rel & (enq_rel_len > LenMax);

  qs_bank_sched_stage #(
    .BanksN    (BANKS_N),
    .BidW      (BidW),
    .ReqState  (BankIdle),
    .BusyState (BankLoading)
  ) u_enq (
    .clk       (clk),
    .rst       (rst),
    .req       (enq_req),
    .rel       (enq_rel),
    .rel_veto  (enq_len_bad),
    .ptr_state (state_q[enq_ptr]),
    .ptr       (enq_ptr),
    .acq       (enq_acq),
    .acq_state (enq_acq_st),
    .rel_ok    (enq_rel_ok),
    .rel_state (enq_rel_st),
    .rel_err   (enq_rel_err),
    .gnt_r     (enq_gnt_r),
    .idx_r     (enq_idx_r)
  );

  qs_bank_sched_stage #(
    .BanksN    (BANKS_N),
    .BidW      (BidW),
    .ReqState  (BankReady),
    .BusyState (BankSorting)
  ) u_srt (
    .clk       (clk),
    .rst       (rst),
    .req       (srt_req),
    .rel       (srt_rel),
    .rel_veto  (1'b0),
    .ptr_state (state_q[srt_ptr]),
    .ptr       (srt_ptr),
    .acq       (srt_acq),
    .acq_state (srt_acq_st),
    .rel_ok    (srt_rel_ok),
    .rel_state (srt_rel_st),
    .rel_err   (srt_rel_err),
    .gnt_r     (srt_gnt_r),
    .idx_r     (srt_idx_r)
  );

  qs_bank_sched_stage #(
    .BanksN    (BANKS_N),
    .BidW      (BidW),
    .ReqState  (BankSorted),
    .BusyState (BankUnloading)
  ) u_deq (
    .clk       (clk),
    .rst       (rst),
    .req       (deq_req),
    .rel       (deq_rel),
    .rel_veto  (1'b0),
    .ptr_state (state_q[deq_ptr]),
    .ptr       (deq_ptr),
    .acq       (deq_acq),
    .acq_state (deq_acq_st),
    .rel_ok    (deq_rel_ok),
    .rel_state (deq_rel_st),
    .rel_err   (deq_rel_err),
    .gnt_r     (deq_gnt_r),
    .idx_r     (deq_idx_r)
  );

  // Apply stage strobes; each stage touches only banks in its own statuses, so no conflicts.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (enq_acq)    state_d[enq_ptr]   = enq_acq_st;
    if (srt_acq)    state_d[srt_ptr]   = srt_acq_st;
    if (deq_acq)    state_d[deq_ptr]   = deq_acq_st;
    if (enq_rel_ok) begin
      state_d[enq_idx_r] = enq_rel_st;
      len_d[enq_idx_r]   = enq_rel_len;
    end
    if (srt_rel_ok) state_d[srt_idx_r] = srt_rel_st;
    if (deq_rel_ok) state_d[deq_idx_r] = deq_rel_st;
    err_d = err_q | enq_len_bad | enq_rel_err | srt_rel_err | deq_rel_err;
  end

  // All banks idle implies no stage owns a bank, since ownership means a busy status.
  always_comb begin
    idle = 1'b1;
    for (int i = 0; i < int'(BANKS_N); i++) begin
      if (state_q[i] != BankIdle) idle = 1'b0;
    end
  end

  // Bank status/length array, captured lengths and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(BANKS_N); i++) begin
        state_q[i] <= BankIdle;
        len_q[i]   <= '0;
      end
      srt_len_q <= '0;
      deq_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < int'(BANKS_N); i++) begin
        state_q[i] <= state_d[i];
        len_q[i]   <= len_d[i];
      end
      if (srt_acq) srt_len_q <= len_q[srt_ptr];
      if (deq_acq) deq_len_q <= len_q[deq_ptr];
      err_q <= err_d;
    end
  end

  assign srt_len_r = srt_len_q;
  assign deq_len_r = deq_len_q;
  assign idle_r    = idle;
  assign err_r     = err_q;

endmodule

// File: tb/tb_qs_bank_sched.sv
// Bench for qs_bank_sched: per-cycle reference model plus directed literal checks.
module tb_qs_bank_sched;
  import qs_bank_sched_pkg::*;

  localparam int NB = BANKS_N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enq_req = 0, enq_rel = 0, srt_req = 0, srt_rel = 0, deq_req = 0, deq_rel = 0;
  logic [LEN_W-1:0] enq_rel_len = '0;
  logic             enq_gnt_r, srt_gnt_r, deq_gnt_r, idle_r, err_r;
  logic [BID_W-1:0] enq_idx_r, srt_idx_r, deq_idx_r;
  logic [LEN_W-1:0] srt_len_r, deq_len_r;

  always #5 clk = ~clk;

  qs_bank_sched dut (
    .clk         (clk),
    .rst         (rst),
    .enq_req     (enq_req),
    .enq_gnt_r   (enq_gnt_r),
    .enq_idx_r   (enq_idx_r),
    .enq_rel     (enq_rel),
    .enq_rel_len (enq_rel_len),
    .srt_req     (srt_req),
    .srt_gnt_r   (srt_gnt_r),
    .srt_idx_r   (srt_idx_r),
    .srt_len_r   (srt_len_r),
    .srt_rel     (srt_rel),
    .deq_req     (deq_req),
    .deq_gnt_r   (deq_gnt_r),
    .deq_idx_r   (deq_idx_r),
    .deq_len_r   (deq_len_r),
    .deq_rel     (deq_rel),
    .idle_r      (idle_r),
    .err_r       (err_r)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model. Lifecycle positions 0..5; stage s waits for 2s, holds 2s+1, frees to 2s+2.
  int m_st[NB];
  int m_len[NB];
  int m_ptr[3];
  bit m_own[3];
  bit m_gnt[3];
  int m_idx[3];
  int m_olen[3];
  bit m_err;

  task automatic model_step();
    int st_n[NB];
    int len_n[NB];
    bit rq[3];
    bit rl[3];
    bit bad;
    if (rst) begin
      for (int b = 0; b < NB; b++) begin m_st[b] = 0; m_len[b] = 0; end
      for (int s = 0; s < 3; s++) begin
        m_ptr[s] = 0; m_own[s] = 0; m_gnt[s] = 0; m_idx[s] = 0; m_olen[s] = 0;
      end
      m_err = 0;
      return;
    end
    rq = '{enq_req, srt_req, deq_req};
    rl = '{enq_rel, srt_rel, deq_rel};
    bad = enq_rel && (int'(enq_rel_len) > N);
    st_n = m_st;
    len_n = m_len;
    if (bad) m_err = 1;
    for (int s = 0; s < 3; s++) begin
      if (rl[s] && !m_own[s]) m_err = 1;
      if (rq[s] && !m_own[s] && !rl[s] && m_st[m_ptr[s]] == 2 * s) begin
        m_gnt[s] = 1;
        m_idx[s] = m_ptr[s];
        m_olen[s] = m_len[m_ptr[s]];
        st_n[m_ptr[s]] = 2 * s + 1;
        m_own[s] = 1;
        m_ptr[s] = (m_ptr[s] + 1) % NB;
      end else begin
        m_gnt[s] = 0;
        if (rl[s] && m_own[s] && !(s == 0 && bad)) begin
          st_n[m_idx[s]] = (2 * s + 2) % 6;
          if (s == 0) len_n[m_idx[s]] = int'(enq_rel_len);
          m_own[s] = 0;
        end
      end
    end
    m_st = st_n;
    m_len = len_n;
  endtask

  function automatic bit model_idle();
    for (int b = 0; b < NB; b++) if (m_st[b] != 0) return 0;
    return 1;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Whole-output compare every cycle on the falling edge.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cycle_outputs",
            32'({enq_gnt_r, enq_idx_r, srt_gnt_r, srt_idx_r, srt_len_r,
                 deq_gnt_r, deq_idx_r, deq_len_r, idle_r, err_r}),
            32'({m_gnt[0], BID_W'(m_idx[0]), m_gnt[1], BID_W'(m_idx[1]), LEN_W'(m_olen[1]),
                 m_gnt[2], BID_W'(m_idx[2]), LEN_W'(m_olen[2]), model_idle(), m_err}));
    end
  end

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    {enq_req, enq_rel, srt_req, srt_rel, deq_req, deq_rel} = '0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    @(posedge clk);
    #1 chk_en = 1;
    @(negedge clk);
    rst = 0;
    check("rst_idle", idle_r, 1);
    check("rst_gnt", {enq_gnt_r, srt_gnt_r, deq_gnt_r}, 0);
    check("rst_err", err_r, 0);

    // First enqueue grant; a held request while owning gets nothing.
    enq_req = 1;
    sample();
    check("t1_enq_gnt", enq_gnt_r, 1);
    check("t1_enq_idx", enq_idx_r, 0);
    check("t1_idle", idle_r, 0);
    sample();
    check("t1_own_no_gnt", enq_gnt_r, 0);

    // Length flows from enqueue through sort and dequeue.
    @(negedge clk); enq_req = 0; enq_rel = 1; enq_rel_len = 5;
    @(negedge clk); enq_rel = 0; srt_req = 1;
    sample();
    check("t2_srt_gnt", srt_gnt_r, 1);
    check("t2_srt_idx", srt_idx_r, 0);
    check("t2_srt_len", srt_len_r, 5);
    @(negedge clk); srt_req = 0; srt_rel = 1;
    @(negedge clk); srt_rel = 0; deq_req = 1;
    sample();
    check("t2_deq_gnt", deq_gnt_r, 1);
    check("t2_deq_len", deq_len_r, 5);
    @(negedge clk); deq_req = 0; deq_rel = 1;
    sample();
    check("t2_idle", idle_r, 1);
    @(negedge clk); deq_rel = 0;

    // Fill all banks, stall, then free bank 0 and watch enq wrap to it.
    do_reset();
    for (int i = 0; i < NB; i++) begin
      enq_req = 1;
      sample();
      check("t3_fill_gnt", enq_gnt_r, 1);
      check("t3_fill_idx", enq_idx_r, i);
      @(negedge clk); enq_req = 0; enq_rel = 1; enq_rel_len = LEN_W'(i + 1);
      @(negedge clk); enq_rel = 0;
    end
    enq_req = 1;
    repeat (3) begin
      sample();
      check("t3_full_stall", enq_gnt_r, 0);
    end
    @(negedge clk); srt_req = 1;
    sample();
    check("t3_srt_idx", srt_idx_r, 0);
    check("t3_srt_len", srt_len_r, 1);
    @(negedge clk); srt_req = 0; srt_rel = 1;
    @(negedge clk); srt_rel = 0; deq_req = 1;
    sample();
    check("t3_deq_gnt", deq_gnt_r, 1);
    @(negedge clk); deq_req = 0; deq_rel = 1;
    sample();
    check("t3_enq_wait", enq_gnt_r, 0);
    @(negedge clk); deq_rel = 0;
    sample();
    check("t3_enq_wrap_gnt", enq_gnt_r, 1);
    check("t3_enq_wrap_idx", enq_idx_r, 0);
    @(negedge clk); enq_req = 0;

    // Simultaneous enq_rel/srt_rel with deq waiting on the bank being sorted.
    do_reset();
    enq_req = 1;
    @(negedge clk); enq_req = 0; enq_rel = 1; enq_rel_len = 3;
    @(negedge clk); enq_rel = 0; srt_req = 1; enq_req = 1;
    sample();
    check("t4_srt_gnt", srt_gnt_r, 1);
    check("t4_enq_idx", enq_idx_r, 1);
    @(negedge clk); srt_req = 0; enq_req = 0; enq_rel = 1; enq_rel_len = 6; srt_rel = 1;
    deq_req = 1;
    sample();
    check("t4_deq_early", deq_gnt_r, 0);
    @(negedge clk); enq_rel = 0; srt_rel = 0;
    sample();
    check("t4_deq_gnt", deq_gnt_r, 1);
    check("t4_deq_idx", deq_idx_r, 0);
    check("t4_deq_len", deq_len_r, 3);
    @(negedge clk); deq_req = 0; srt_req = 1;
    sample();
    check("t4_srt_idx1", srt_idx_r, 1);
    check("t4_srt_len6", srt_len_r, 6);
    @(negedge clk); srt_req = 0; srt_rel = 1;
    @(negedge clk); srt_rel = 0;

    // Release without ownership sets a sticky error.
    check("t5_err_before", err_r, 0);
    srt_rel = 1;
    sample();
    check("t5_err_set", err_r, 1);
    @(negedge clk); srt_rel = 0;
    repeat (3) begin
      sample();
      check("t5_err_sticky", err_r, 1);
    end

    // Oversize length is rejected; the bank stays with enq until a valid release.
    do_reset();
    check("t5b_err_clr", err_r, 0);
    enq_req = 1;
    @(negedge clk); enq_req = 0; enq_rel = 1; enq_rel_len = LEN_W'(N + 1);
    sample();
    check("t5b_len_err", err_r, 1);
    @(negedge clk); enq_rel_len = 2;
    @(negedge clk); enq_rel = 0; srt_req = 1;
    sample();
    check("t5b_srt_len", srt_len_r, 2);
    @(negedge clk); srt_req = 0;

    // All three stages owning (incl. a zero-length bank), then reset.
    do_reset();
    enq_req = 1;
    @(negedge clk); enq_req = 0; enq_rel = 1; enq_rel_len = 4;
    @(negedge clk); enq_rel = 0; srt_req = 1; enq_req = 1;
    @(negedge clk); srt_req = 0; enq_req = 0; srt_rel = 1; enq_rel = 1; enq_rel_len = 0;
    @(negedge clk); srt_rel = 0; enq_rel = 0; deq_req = 1; srt_req = 1; enq_req = 1;
    sample();
    check("t6_all_gnt", {enq_gnt_r, srt_gnt_r, deq_gnt_r}, 3'b111);
    check("t6_idx", {enq_idx_r, srt_idx_r, deq_idx_r}, {2'd2, 2'd1, 2'd0});
    check("t6_zero_len", srt_len_r, 0);
    check("t6_deq_len", deq_len_r, 4);
    @(negedge clk); {enq_req, srt_req, deq_req} = '0; rst = 1;
    sample();
    check("t6_rst_gnt", {enq_gnt_r, srt_gnt_r, deq_gnt_r}, 0);
    check("t6_rst_idle", idle_r, 1);
    @(negedge clk); rst = 0; enq_req = 1;
    sample();
    check("t6_enq_after_rst", enq_gnt_r, 1);
    check("t6_enq_idx0", enq_idx_r, 0);
    @(negedge clk); enq_req = 0;

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
